// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial pattern detector with match counting and target stop.
// Latency: detector_out and match_count update one cycle after the final pattern bit is sampled.
// Backpressure: config is accepted only while idle (cfg_ready); serial bits are consumed only on in_valid.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   cfg_valid/cfg_ready          config handshake; cfg_ready is high only in IDLE
//   cfg_pattern/len/overlap/target  pattern (bit [len-1] first), length, overlap mode, stop target
//   cfg_err                      one-cycle pulse when an offered config is rejected
//   start, stop                  run control levels; stop has priority
//   sequence_in, in_valid        qualified serial input stream
//   detector_out                 one-cycle pulse per match
//   match_count                  saturating match counter for the current or last run
//   busy, done                   state flags for RUN and DONE
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               sequence_in,
    input  logic               in_valid,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // State and stored configuration
    state_t               state_q,   state_d;
    logic [MAX_LEN-1:0]   pat_q,     pat_d;
    logic [LEN_W-1:0]     len_q,     len_d;
    logic                 ovl_q,     ovl_d;
    logic [CNT_W-1:0]     tgt_q,     tgt_d;
    logic                 loaded_q,  loaded_d;

    // Matcher datapath
    logic [MAX_LEN-1:0]   hist_q,    hist_d;
    logic [LEN_W-1:0]     fill_q,    fill_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 det_q,     det_d;
    logic                 err_q,     err_d;

    // Candidate values if the current bit is consumed
    logic [MAX_LEN-1:0]   hist_new;
    logic [LEN_W-1:0]     fill_new;
    logic [CNT_W-1:0]     cnt_new;
    logic [MAX_LEN-1:0]   len_mask;
    logic                 hit;
    logic                 cfg_bad;

    // Low len_q bits set; only those bits take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        hist_new = {hist_q[MAX_LEN-2:0], sequence_in};
        fill_new = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);
        cnt_new  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // fill gates the compare so stale history (before run start or after a
        // non-overlapping match) can never produce a match.
        hit      = (fill_new >= len_q) && ((hist_new & len_mask) == (pat_q & len_mask));
        cfg_bad  = (cfg_len == '0) || (cfg_len > MAX_LEN_L);
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        tgt_d    = tgt_q;
        loaded_d = loaded_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        det_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        pat_d    = cfg_pattern;
                        len_d    = cfg_len;
                        ovl_d    = cfg_overlap;
                        tgt_d    = cfg_target;
                        loaded_d = 1'b1;
                    end
                end
                // start uses the config already stored, not one arriving this cycle
                if (start && !stop && loaded_q) begin
                    state_d = S_RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end

            S_RUN: begin
                if (stop) begin
                    // bit offered in a stop cycle is dropped
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    hist_d = hist_new;
                    fill_d = fill_new;
                    if (hit) begin
                        det_d = 1'b1;
                        cnt_d = cnt_new;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if ((tgt_q != '0) && (cnt_new == tgt_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            tgt_q    <= '0;
            loaded_q <= 1'b0;
            hist_q   <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            det_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            tgt_q    <= tgt_d;
            loaded_q <= loaded_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            det_q    <= det_d;
            err_q    <= err_d;
        end
    end

    // Every output is a register or a decode of the state register.
    assign cfg_ready    = (state_q == S_IDLE);
    assign busy         = (state_q == S_RUN);
    assign done         = (state_q == S_DONE);
    assign detector_out = det_q;
    assign cfg_err      = err_q;
    assign match_count  = cnt_q;

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run-time controller for the serial pattern-detection path. It accepts a programmable bit pattern (length 1..MAX_LEN) over a config handshake and gates a qualified serial bit stream into a Moore-style matcher. It counts detections in overlapping or non-overlapping mode and stops after a programmed match target. It sits between the stimulus/host side and the detector output consumers, and replaces fixed-pattern detector FSMs wherever the pattern must change at run time.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- LEN_W, 4, width of cfg_len; must hold MAX_LEN
- CNT_W, 8, width of match counter and target

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- cfg_valid  in  1  config offer
- cfg_ready  out  1  high only in IDLE
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_target  in  CNT_W  stop after this many matches; 0 = run until stop
- cfg_err  out  1  one-cycle pulse when a config is rejected
- start  in  1  level sampled per cycle; starts a run
- stop  in  1  level sampled per cycle; aborts a run
- sequence_in  in  1  serial data bit
- in_valid  in  1  sequence_in is consumed only when high
- detector_out  out  1  one-cycle pulse per match
- match_count  out  CNT_W  matches in the current or last run
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE and clears all registers, including cfg_loaded.
- Config transfer occurs when cfg_valid and cfg_ready are both high. A transfer is rejected when cfg_len is 0 or greater than MAX_LEN. On rejection:
  - cfg_err pulses on the next cycle.
  - The stored config is unchanged.
  - A valid transfer latches all cfg_* fields and sets cfg_loaded.
- IDLE -> RUN on start when cfg_loaded = 1. Entering RUN clears history, fill and match_count.
  - start with cfg_loaded = 0 is ignored.
- RUN, for each cycle with in_valid = 1:
  - The history register shifts left, with sequence_in entering at bit 0.
  - fill increments, saturating at MAX_LEN.
  - A match is fill_new >= len together with hist_new[len-1:0] == pattern[len-1:0].
- On a match:
  - Pulse detector_out.
  - Increment match_count; it saturates at 2^CNT_W-1.
  - If cfg_overlap = 0, fill is cleared to 0. If cfg_overlap = 1, fill is kept.
- Cycles with in_valid = 0 change nothing.
- RUN -> DONE when cfg_target != 0 and match_count reaches cfg_target. Bits arriving after that are ignored.
- RUN -> IDLE on stop. match_count is retained.
- DONE -> RUN on start (clears as above). DONE -> IDLE on stop.
- When start and stop are asserted together, stop wins. The input bit in a stop cycle is not consumed.
- Reset mid-run returns to IDLE on the next edge; the config is lost.

## Timing
- All outputs are registered.
- Reset values: cfg_ready = 1, cfg_err = 0, detector_out = 0, match_count = 0, busy = 0, done = 0.
- detector_out is high for exactly one cycle. It follows the edge that samples the final pattern bit (Moore latency of 1).
- match_count updates on the same cycle as detector_out.
- done rises on the same cycle as the detector_out of the target match. busy falls on that same cycle.
- cfg_ready drops the cycle after entering RUN.
- Throughput is one bit per cycle; back-to-back matches produce consecutive detector_out pulses.

## Test plan
- Overlapping pattern: pattern 4'b1011, len 4, overlap 1, target 0; stream 1,0,1,1,0,1,1 with in_valid = 1 -> detector_out pulses after bits 4 and 7; match_count = 2.
- Same config and stream with overlap 0 -> one pulse after bit 4; match_count = 1.
- Match target: pattern 2'b11, len 2, overlap 1, target 3; stream of six 1s -> pulses after bits 2, 3 and 4. done = 1 and busy = 0 coincide with the third pulse; bits 5 and 6 are ignored; match_count = 3.
- Config rejection and gating:
  - cfg_len = 0 -> cfg_err pulse, cfg_loaded stays 0, and a following start is ignored.
  - A config offered during RUN sees cfg_ready = 0 and is not taken.
- in_valid gaps: pattern 1011 with in_valid low for 3 cycles between bits 2 and 3 -> a single pulse one cycle after bit 4 is sampled.
- Control priority:
  - start and stop together in IDLE -> stays IDLE.
  - Reset asserted mid-match in RUN -> all outputs return to their reset values on the next edge.
  - start afterwards is ignored until a new config is loaded.
